// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: out = inp1 - inp2, one bit per clock, LSB first,
// with a registered borrow and a start/ready/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bq_q, bq_d;
    logic             borrow_q, borrow_d;

    logic a_bit, b_bit, diff_bit, bq_next;
    logic last_bit;

    // Full-subtractor cell on the current LSBs of the shifting operands.
    assign a_bit    = a_q[0];
    assign b_bit    = b_q[0];
    assign diff_bit = a_bit ^ b_bit ^ bq_q;
    assign bq_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bq_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        bq_d     = bq_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = inp1;
                    b_d     = inp2;
                    bq_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // Entering at the MSB means bit i settles at position i after WIDTH shifts.
                res_d = {diff_bit, res_q[WIDTH-1:1]};
                bq_d  = bq_next;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    out_d    = {diff_bit, res_q[WIDTH-1:1]};
                    borrow_d = bq_next;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            bq_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            bq_q     <= bq_d;
            borrow_q <= borrow_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign out    = out_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors with
// hand-computed results plus random pairs against a modular-difference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] inp1;
    logic [W-1:0] inp2;
    logic         ready;
    logic [W-1:0] out;
    logic         borrow;
    logic         done;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .inp1   (inp1),
        .inp2   (inp2),
        .ready  (ready),
        .out    (out),
        .borrow (borrow),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic b);
        exp_t e;
        e.d = d;
        e.b = b;
        sb_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every done pulse and watches out stability.
    logic [W-1:0] prev_out = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_out = out;
        end else begin
            check("done_with_ready", {31'b0, done & ready}, 32'd0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out", {24'b0, out}, {24'b0, e.d});
                    check("borrow", {31'b0, borrow}, {31'b0, e.b});
                end
            end else begin
                check("out_stable", {24'b0, out}, {24'b0, prev_out});
            end
            prev_out = out;
        end
    end

    // Must be called at a falling edge; returns at a falling edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d_exp, input logic b_exp, input bit disturb);
        int n;
        int lat;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, ready}, 32'd1);
        start = 1'b1;
        inp1  = a;
        inp2  = b;
        push_exp(d_exp, b_exp);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int j = 1; j <= 30; j++) begin
            if (done) begin
                lat = j;
                break;
            end
            if (disturb && j == 3) begin
                start = 1'b1;
                inp1  = ~a;
                inp2  = ~b;
            end else if (disturb && j == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("done_latency", lat, W + 1);
        @(negedge clk);
        check("ready_after_done", {31'b0, ready}, 32'd1);
        check("done_single_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n_done;
        int           idx[$];
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        inp1  = '0;
        inp2  = '0;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_out", {24'b0, out}, 32'd0);
        check("rst_borrow", {31'b0, borrow}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        #11 rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        do_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
        do_op(8'h80, 8'h81, 8'hFF, 1'b1, 1'b0);
        do_op(8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0);

        // Start and operand changes during RUN must not restart or alter the op.
        do_op(8'h47, 8'h12, 8'h35, 1'b0, 1'b1);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_second_done", n_done, 0);

        // Continuous start: exactly three accepted ops, dones every W+2 cycles.
        push_exp(8'h7F, 1'b0);
        push_exp(8'h7F, 1'b0);
        push_exp(8'h7F, 1'b0);
        start = 1'b1;
        inp1  = 8'h80;
        inp2  = 8'h01;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 22) start = 1'b0;
            if (done) idx.push_back(j);
        end
        check("b2b_count", idx.size(), 3);
        if (idx.size() == 3) begin
            check("b2b_first", idx[0], W + 1);
            check("b2b_period1", idx[1] - idx[0], W + 2);
            check("b2b_period2", idx[2] - idx[1], W + 2);
        end

        // Asynchronous reset mid-RUN discards the operation.
        start = 1'b1;
        inp1  = 8'h33;
        inp2  = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", {31'b0, ready}, 32'd1);
        check("arst_out", {24'b0, out}, 32'd0);
        check("arst_borrow", {31'b0, borrow}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            do_op(ra, rb, ra - rb, (ra < rb), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing inp1 - inp2 one bit per clock, LSB first. It uses a half/full-subtractor cell with a registered borrow. This is the subtract-direction counterpart of the half-adder datapath cell. It sits in the arithmetic datapath where area matters more than throughput, and uses a start/ready/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal: 2..32).

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request; sampled only when ready=1
inp1  input  WIDTH  minuend; captured on accepted start
inp2  input  WIDTH  subtrahend; captured on accepted start
ready  output  1  high when in IDLE; start is accepted this cycle
out  output  WIDTH  difference, (inp1 - inp2) mod 2^WIDTH; held until next completion
borrow  output  1  final borrow-out; 1 iff inp1 < inp2 (unsigned); held with out
done  output  1  one-cycle pulse when out/borrow update

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE; ready=1; out=0; borrow=0; done=0.
  - Internal operand shift registers, partial-result register, bit counter and borrow flop all cleared.
  - An operation in progress is discarded; out/borrow do not show partial values.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 at a rising edge: capture inp1/inp2, clear the borrow flop and bit counter, go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - ready=0. Each edge processes bit i = counter.
  - d = a[i] ^ b[i] ^ bq.
  - bq_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bq).
  - d shifts into the partial-result register MSB-ward so bit i lands at position i after WIDTH shifts. The operands shift right. The counter increments.
  - On the edge processing bit WIDTH-1: load out with the complete partial result, load borrow with bq_next, go to DONE.
- DONE: ready=0; done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH; ready high again after edge k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while ready=0 (RUN or DONE): ignored, not queued. inp1/inp2 changes during RUN have no effect.
- start held high continuously: a new operation is accepted at every IDLE cycle, so back-to-back ops repeat every WIDTH+2 cycles.
- out and borrow change only at DONE entry or on reset. They are stable between completions, including while the next operation runs.
- Wrap-around: the result is modulo 2^WIDTH. Equal operands give out=0, borrow=0.
- Combinational outputs: none. ready and done decode directly from registered state.

Test Plan:
- WIDTH=8, reset then start with inp1=8'h05, inp2=8'h03 -> done pulses exactly 9 cycles after the accepting edge; out=8'h02, borrow=0; ready returns 1 the following cycle.
- inp1=8'h03, inp2=8'h05 -> out=8'hFE, borrow=1. inp1=8'h00, inp2=8'hFF -> out=8'h01, borrow=1. inp1=inp2=8'hA5 -> out=8'h00, borrow=0.
- Pulse start again, and change inp1/inp2, 3 cycles into RUN -> no restart; the original result appears; done is a single pulse; no second done follows.
- Hold start=1 with constant operands 8'h80 - 8'h01 -> done pulses every 10 cycles; out=8'h7F, borrow=0 each time; out is stable between pulses.
- Assert rst_n=0 asynchronously mid-RUN (between edges) -> immediately ready=1, out=0, borrow=0, done=0. After release a fresh 8'h10 - 8'h01 gives out=8'h0F, borrow=0.
- Randomised 1000 operand pairs checked against a reference model of (inp1 - inp2) mod 256 and inp1<inp2 -> zero mismatches; done never asserted when ready=1.
